booth_wallace_mult_pipe: RTL and testbench

BOOTH_WALLACE_MULT_PIPE -- requirements
Module: booth_wallace_mult_pipe

---
 rtl/booth_wallace_mult_pipe.sv | 152 +++++++++++++++
 tb/tb_booth_wallace_mult_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_wallace_mult_pipe.sv
// Three-stage pipelined radix-4 Booth multiplier with carry-save reduction,
// valid/ready handshake on both sides, tag passthrough and synchronous flush.
module booth_wallace_mult_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned NPP = WIDTH / 2 + 1;
  localparam int unsigned BW  = WIDTH + 3;

  logic             s1_valid;
  logic             s2_valid;
  logic [PW-1:0]    s1_pp [NPP];
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;
  logic [PW-1:0]    s2_sum;
  logic [PW-1:0]    s2_carry;

  logic s1_ready, s2_ready, s3_ready;
  logic accept, ld2, ld3;

  logic [BW-1:0] b_ext;
  logic [PW-1:0] a_ext;
  logic [2:0]    grp;
  logic [PW-1:0] mag;
  logic          neg;
  logic [PW-1:0] pp;
  logic [PW-1:0] pp_c [NPP];

  logic [PW-1:0] red_sum;
  logic [PW-1:0] red_carry;
  logic [PW-1:0] sh;
  logic [PW-1:0] nsum;

  // A stage can take new data when empty or when its content moves on this cycle.
  assign s3_ready = !out_valid || out_ready;
  assign s2_ready = !s2_valid || s3_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = !rst && !flush && s1_ready;
  assign accept   = in_valid && in_ready;
  assign ld2      = s1_valid && s2_ready && !flush;
  assign ld3      = s2_valid && s3_ready && !flush;

  // Radix-4 Booth digits over the mode-extended multiplier; LSB pad is the implicit b[-1].
  always_comb begin
    a_ext = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
    b_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
    grp   = '0;
    mag   = '0;
    neg   = 1'b0;
    pp    = '0;
    for (int i = 0; i < int'(NPP); i++) begin
      grp = b_ext[2*i +: 3];
      mag = '0;
      neg = 1'b0;
      case (grp)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext << 1;
        3'b100: begin
          mag = a_ext << 1;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = a_ext;
          neg = 1'b1;
        end
        default:        mag = '0;
      endcase
      pp      = neg ? (~mag + PW'(1)) : mag;
      pp_c[i] = pp << (2 * i);
    end
  end

  // Carry-save array of 3:2 compressors; carry row is kept unshifted (weight 2).
  always_comb begin
    red_sum   = s1_pp[0];
    red_carry = '0;
    sh        = '0;
    nsum      = '0;
    for (int i = 1; i < int'(NPP); i++) begin
      sh        = red_carry << 1;
      nsum      = red_sum ^ sh ^ s1_pp[i];
      red_carry = (red_sum & sh) | (red_sum & s1_pp[i]) | (sh & s1_pp[i]);
      red_sum   = nsum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid  <= in_valid;
      if (s2_ready) s2_valid  <= s1_valid;
      if (s3_ready) out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NPP); i++) s1_pp[i] <= '0;
      s1_tag <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(NPP); i++) s1_pp[i] <= pp_c[i];
      s1_tag <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (ld2) begin
      s2_sum   <= red_sum;
      s2_carry <= red_carry;
      s2_tag   <= s1_tag;
    end
  end

  // Final carry-propagate add; the carry bit shifted past the MSB is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_product <= '0;
      out_tag     <= '0;
    end else if (ld3) begin
      out_product <= s2_sum + (s2_carry << 1);
      out_tag     <= s2_tag;
    end
  end

endmodule

// File: tb/tb_booth_wallace_mult_pipe.sv
// Bench for booth_wallace_mult_pipe: directed corner cases plus a random mixed
// stream, all checked against a plain-arithmetic scoreboard.
module tb_booth_wallace_mult_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic [PW-1:0] out_product;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [TW-1:0] t;
  } exp_t;

  exp_t q[$];

  booth_wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return PW'(pa * pb);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return W'(0);
      1:       return W'(16'hFFFF);
      2:       return W'(16'h8000);
      3:       return W'(16'h7FFF);
      4:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are sampled at negedge, describing the coming posedge.
  logic          stall_q = 1'b0;
  logic [PW-1:0] held_p;
  logic [TW-1:0] held_t;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_product", 64'(out_product), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_product", 64'(out_product), 64'(held_p));
        check("hold_tag", 64'(out_tag), 64'(held_t));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL phantom_output: got tag 0x%0h product 0x%0h, expected no output", out_tag, out_product);
        end else begin
          e = q.pop_front();
          check("product", 64'(out_product), 64'(e.p));
          check("tag", 64'(out_tag), 64'(e.t));
        end
      end
      if (in_valid && in_ready) begin
        e.p = ref_prod(in_signed, in_a, in_b);
        e.t = in_tag;
        q.push_back(e);
      end
      if (flush) q.delete();
      stall_q = out_valid && !out_ready && !flush;
      held_p  = out_product;
      held_t  = out_tag;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int idx, n0, sent, budget;
    logic [W-1:0]  sa[3], sb[3], da[5], db[5];
    logic [PW-1:0] sp[3];
    logic          ds[5];
    logic [TW-1:0] dt[5];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'(1));

    // Unsigned full-scale product and exact latency.
    @(posedge clk); #1;
    in_valid = 1'b1; in_signed = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF; in_tag = 4'h3;
    @(negedge clk);
    check("umax_accept", 64'(in_ready), 64'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("umax_lat1", 64'(out_valid), 64'(0));
    @(negedge clk); check("umax_lat2", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("umax_valid", 64'(out_valid), 64'(1));
    check("umax_product", 64'(out_product), 64'(32'hFFFE0001));
    check("umax_tag", 64'(out_tag), 64'(4'h3));

    // Signed corner cases back-to-back.
    sa[0] = 16'hFFFF; sb[0] = 16'hFFFF; sp[0] = 32'h00000001;
    sa[1] = 16'h8000; sb[1] = 16'h8000; sp[1] = 32'h40000000;
    sa[2] = 16'h8000; sb[2] = 16'h7FFF; sp[2] = 32'hC0008000;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_signed = 1'b1; in_a = sa[i]; in_b = sb[i]; in_tag = TW'(5 + i);
      @(negedge clk);
      check("b2b_accept", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(out_valid), 64'(1));
      check("b2b_product", 64'(out_product), 64'(sp[i]));
      check("b2b_tag", 64'(out_tag), 64'(5 + i));
    end

    // Backpressure: three fill the pipe, then input stalls; drain in order.
    for (int i = 0; i < 5; i++) begin
      da[i] = W'($urandom); db[i] = W'($urandom); ds[i] = 1'($urandom); dt[i] = TW'(8 + i);
    end
    @(posedge clk); #1 out_ready = 1'b0;
    idx = 0;
    n0  = n_out;
    repeat (8) begin
      in_valid = (idx < 5);
      if (idx < 5) begin
        in_signed = ds[idx]; in_a = da[idx]; in_b = db[idx]; in_tag = dt[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(idx), 64'(3));
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_first_product", 64'(out_product), 64'(ref_prod(ds[0], da[0], db[0])));
    check("bp_first_tag", 64'(out_tag), 64'(dt[0]));
    @(posedge clk); #1 out_ready = 1'b1;
    budget = 0;
    while ((idx < 5 || q.size() != 0 || out_valid) && budget < 30) begin
      in_valid = (idx < 5);
      if (idx < 5) begin
        in_signed = ds[idx]; in_a = da[idx]; in_b = db[idx]; in_tag = dt[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 64'(idx), 64'(5));
    check("bp_out_count", 64'(n_out - n0), 64'(5));

    // Flush with a full pipe; offered input during flush is refused.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_signed = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom); in_tag = 4'h1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_signed = 1'b1; in_a = 16'h1234; in_b = 16'hFEDC; in_tag = 4'hA;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    check("flush_pre_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1 flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("post_flush_accept", 64'(in_ready), 64'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("post_flush_lat1", 64'(out_valid), 64'(0));
    @(negedge clk); check("post_flush_lat2", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("post_flush_valid", 64'(out_valid), 64'(1));
    check("post_flush_product", 64'(out_product), 64'(32'hFFEB3CB0));
    check("post_flush_tag", 64'(out_tag), 64'(4'hA));

    // Reset pulse with two transactions in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_signed = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'(14 + i);
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", 64'(out_valid), 64'(0));
    check("rstmid_product", 64'(out_product), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    n0 = n_out;
    repeat (6) @(negedge clk);
    check("rstmid_no_old", 64'(n_out - n0), 64'(0));

    // Random mixed-mode stream with random backpressure.
    @(posedge clk); #1;
    sent   = 0;
    budget = 0;
    n0     = n_out;
    while (sent < 10000 && budget < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_signed = 1'($urandom);
      in_a      = pick();
      in_b      = pick();
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("rand_sent", 64'(sent), 64'(10000));
    check("rand_out_count", 64'(n_out - n0), 64'(sent));
    check("rand_queue_empty", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
